// File: rtl/control_turnos_batalla.sv
// rtl/control_turnos_batalla.sv - turn scheduler, damage tracker and end-of-game detector for player-vs-PC battleship
module control_turnos_batalla #(
    parameter int unsigned NUM_BARCOS     = 5,
    parameter int unsigned TIMEOUT_CICLOS = 250000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_jug_disparo,
    input  logic                  i_jug_impacto,
    input  logic [2:0]            i_jug_barco,
    input  logic                  i_pc_disparo,
    input  logic                  i_pc_impacto,
    input  logic [2:0]            i_pc_barco,
    output logic                  o_turno,
    output logic [NUM_BARCOS-1:0] o_barcos_jug,
    output logic [NUM_BARCOS-1:0] o_barcos_pc,
    output logic                  o_disparo_ack,
    output logic                  o_timeout,
    output logic                  o_fin_juego,
    output logic                  o_ganador
);

    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TURNO_JUG = 3'd1,
        TURNO_PC  = 3'd2,
        RESOLVER  = 3'd3,
        FIN       = 3'd4
    } estado_t;

    estado_t               r_estado;
    logic                  r_turno;
    logic                  r_hit_valid;
    logic                  r_ack;
    logic                  r_timeout;
    logic                  r_fin;
    logic                  r_ganador;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_vida_jug [NUM_BARCOS];
    logic [2:0]            r_vida_pc  [NUM_BARCOS];
    logic [NUM_BARCOS-1:0] r_mask_jug;
    logic [NUM_BARCOS-1:0] r_mask_pc;

    logic                  w_en_turno;
    logic                  w_disparo;
    logic                  w_impacto;
    logic [2:0]            w_barco;
    logic [NUM_BARCOS-1:0] w_golpe;
    logic [NUM_BARCOS-1:0] w_mask_rival;

    // Only the side holding the turn is listened to; the other side's inputs are dropped.
    assign w_en_turno   = (r_estado == TURNO_JUG) || (r_estado == TURNO_PC);
    assign w_disparo    = w_en_turno && (r_turno ? i_pc_disparo : i_jug_disparo);
    assign w_impacto    = r_turno ? i_pc_impacto : i_jug_impacto;
    assign w_barco      = r_turno ? i_pc_barco : i_jug_barco;
    assign w_mask_rival = r_turno ? r_mask_jug : r_mask_pc;

    // One-hot damage target; out-of-range index or an already-sunk ship yields no bit (a miss).
    always_comb begin
        w_golpe = '0;
        for (int i = 0; i < NUM_BARCOS; i++) begin
            if (w_impacto && (w_barco == 3'(i)) &&
                ((r_turno ? r_vida_jug[i] : r_vida_pc[i]) != 3'd0)) begin
                w_golpe[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_estado    <= IDLE;
            r_turno     <= 1'b0;
            r_hit_valid <= 1'b0;
            r_ack       <= 1'b0;
            r_timeout   <= 1'b0;
            r_fin       <= 1'b0;
            r_ganador   <= 1'b0;
            r_cnt       <= '0;
            r_mask_jug  <= '1;
            r_mask_pc   <= '1;
            for (int i = 0; i < NUM_BARCOS; i++) begin
                r_vida_jug[i] <= 3'(i + 1);
                r_vida_pc[i]  <= 3'(i + 1);
            end
        end else begin
            r_ack     <= 1'b0;
            r_timeout <= 1'b0;
            case (r_estado)
                IDLE, FIN: begin
                    if (i_start) begin
                        r_estado    <= TURNO_JUG;
                        r_turno     <= 1'b0;
                        r_hit_valid <= 1'b0;
                        r_fin       <= 1'b0;
                        r_ganador   <= 1'b0;
                        r_cnt       <= '0;
                        r_mask_jug  <= '1;
                        r_mask_pc   <= '1;
                        for (int i = 0; i < NUM_BARCOS; i++) begin
                            r_vida_jug[i] <= 3'(i + 1);
                            r_vida_pc[i]  <= 3'(i + 1);
                        end
                    end
                end
                TURNO_JUG, TURNO_PC: begin
                    if (w_disparo) begin
                        // Mask bit follows the new counter value on the same edge.
                        for (int i = 0; i < NUM_BARCOS; i++) begin
                            if (w_golpe[i]) begin
                                if (r_turno) begin
                                    r_vida_jug[i] <= r_vida_jug[i] - 3'd1;
                                    r_mask_jug[i] <= (r_vida_jug[i] != 3'd1);
                                end else begin
                                    r_vida_pc[i]  <= r_vida_pc[i] - 3'd1;
                                    r_mask_pc[i]  <= (r_vida_pc[i] != 3'd1);
                                end
                            end
                        end
                        r_hit_valid <= |w_golpe;
                        r_ack       <= 1'b1;
                        r_estado    <= RESOLVER;
                    end else if (r_cnt == LIMITE) begin
                        r_timeout <= 1'b1;
                        r_turno   <= ~r_turno;
                        r_cnt     <= '0;
                        r_estado  <= r_turno ? TURNO_JUG : TURNO_PC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESOLVER: begin
                    r_cnt <= '0;
                    if (w_mask_rival == '0) begin
                        r_estado  <= FIN;
                        r_fin     <= 1'b1;
                        r_ganador <= r_turno;
                    end else if (r_hit_valid) begin
                        r_estado <= r_turno ? TURNO_PC : TURNO_JUG;
                    end else begin
                        r_turno  <= ~r_turno;
                        r_estado <= r_turno ? TURNO_JUG : TURNO_PC;
                    end
                end
                default: r_estado <= IDLE;
            endcase
        end
    end

    assign o_turno       = r_turno;
    assign o_barcos_jug  = r_mask_jug;
    assign o_barcos_pc   = r_mask_pc;
    assign o_disparo_ack = r_ack;
    assign o_timeout     = r_timeout;
    assign o_fin_juego   = r_fin;
    assign o_ganador     = r_ganador;

endmodule

// File: tb/tb_control_turnos_batalla.sv
// tb/tb_control_turnos_batalla.sv - self-checking bench for control_turnos_batalla
module tb_control_turnos_batalla;

    localparam int NB = 5;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          jd = 1'b0, ji = 1'b0, pd = 1'b0, pi = 1'b0;
    logic [2:0]    jb = 3'd0, pb = 3'd0;
    logic          turno, ack, tout, fin, ganador;
    logic [NB-1:0] m_jug, m_pc;

    control_turnos_batalla #(.NUM_BARCOS(NB), .TIMEOUT_CICLOS(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_jug_disparo(jd), .i_jug_impacto(ji), .i_jug_barco(jb),
        .i_pc_disparo(pd), .i_pc_impacto(pi), .i_pc_barco(pb),
        .o_turno(turno), .o_barcos_jug(m_jug), .o_barcos_pc(m_pc),
        .o_disparo_ack(ack), .o_timeout(tout), .o_fin_juego(fin), .o_ganador(ganador)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Game-level reference: remaining hits per ship, whose turn, winner.
    int hp_j[NB];
    int hp_p[NB];
    int m_side;
    int m_done;
    int m_winner;

    function automatic void m_reload();
        for (int i = 0; i < NB; i++) begin
            hp_j[i] = i + 1;
            hp_p[i] = i + 1;
        end
        m_side = 0;
        m_done = 0;
        m_winner = 0;
    endfunction

    function automatic int m_mask(input int side);
        int m = 0;
        for (int i = 0; i < NB; i++)
            if ((side == 0 ? hp_j[i] : hp_p[i]) > 0) m = m | (1 << i);
        return m;
    endfunction

    function automatic void m_shot(input int imp, input int b);
        int hit = 0;
        if (imp != 0 && b < NB) begin
            if (m_side == 0 && hp_p[b] > 0) begin hp_p[b]--; hit = 1; end
            if (m_side == 1 && hp_j[b] > 0) begin hp_j[b]--; hit = 1; end
        end
        if (m_mask(m_side == 0 ? 1 : 0) == 0) begin
            m_done = 1;
            m_winner = m_side;
        end else if (hit == 0) begin
            m_side = 1 - m_side;
        end
    endfunction

    // Drive one shot for one negedge-to-negedge cycle; returns in the cycle after the accept edge.
    task automatic pulse_shot(input int side, input int imp, input int b, input int both, input int st);
        if (side == 0) begin jd = 1'b1; ji = imp[0]; jb = 3'(b); end
        else begin pd = 1'b1; pi = imp[0]; pb = 3'(b); end
        if (both != 0) begin
            if (side == 0) begin pd = 1'b1; pi = 1'b1; pb = 3'd0; end
            else begin jd = 1'b1; ji = 1'b1; jb = 3'd0; end
        end
        start = st[0];
        @(negedge clk);
        jd = 1'b0; ji = 1'b0; jb = 3'd0; pd = 1'b0; pi = 1'b0; pb = 3'd0; start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        int side; int imp; int barco; int both;
        int ack; int mpc; int mjug; int turno_after;
    } vec_t;

    vec_t tv[13];
    int   seen;
    int   side, imp, b, both, st, r;

    initial begin
        tv[0]  = '{0, 0, 0, 0, 1, 'h1f, 'h1f, 1};
        tv[1]  = '{1, 0, 0, 0, 1, 'h1f, 'h1f, 0};
        tv[2]  = '{0, 1, 0, 0, 1, 'h1e, 'h1f, 0};
        tv[3]  = '{0, 1, 4, 1, 1, 'h1e, 'h1f, 0};
        tv[4]  = '{0, 1, 4, 0, 1, 'h1e, 'h1f, 0};
        tv[5]  = '{0, 0, 2, 0, 1, 'h1e, 'h1f, 1};
        tv[6]  = '{1, 1, 4, 0, 1, 'h1e, 'h1f, 1};
        tv[7]  = '{1, 1, 7, 0, 1, 'h1e, 'h1f, 0};
        tv[8]  = '{0, 1, 4, 0, 1, 'h1e, 'h1f, 0};
        tv[9]  = '{0, 1, 0, 0, 1, 'h1e, 'h1f, 1};
        tv[10] = '{1, 0, 3, 0, 1, 'h1e, 'h1f, 0};
        tv[11] = '{0, 1, 4, 0, 1, 'h1e, 'h1f, 0};
        tv[12] = '{0, 1, 4, 0, 1, 'h0e, 'h1f, 0};

        repeat (2) @(negedge clk);
        chk("rst_turno", turno, 0);
        chk("rst_mjug", m_jug, 'h1f);
        chk("rst_mpc", m_pc, 'h1f);
        chk("rst_ack", ack, 0);
        chk("rst_timeout", tout, 0);
        chk("rst_fin", fin, 0);
        chk("rst_ganador", ganador, 0);
        rst_n = 1'b1;
        @(negedge clk);

        pulse_shot(0, 1, 0, 0, 0);
        chk("idle_shot_ignored_ack", ack, 0);
        chk("idle_shot_ignored_mpc", m_pc, 'h1f);
        pulse_start();
        chk("start_turno", turno, 0);

        for (int k = 0; k < 13; k++) begin
            pulse_shot(tv[k].side, tv[k].imp, tv[k].barco, tv[k].both, 0);
            chk($sformatf("vec%0d_ack", k), ack, tv[k].ack);
            chk($sformatf("vec%0d_mpc", k), m_pc, tv[k].mpc);
            chk($sformatf("vec%0d_mjug", k), m_jug, tv[k].mjug);
            chk($sformatf("vec%0d_turno_resolver", k), turno, tv[k].side);
            @(negedge clk);
            chk($sformatf("vec%0d_ack_low", k), ack, 0);
            chk($sformatf("vec%0d_turno_after", k), turno, tv[k].turno_after);
        end

        // Off-turn shot alone, then a full timeout on the player's turn.
        pulse_shot(1, 1, 0, 0, 0);
        chk("offturn_ack", ack, 0);
        chk("offturn_mjug", m_jug, 'h1f);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (tout) seen = 1;
        end
        chk("timeout_early", seen, 0);
        chk("timeout_turno_before", turno, 0);
        @(negedge clk);
        chk("timeout_pulse", tout, 1);
        chk("timeout_turno_after", turno, 1);
        @(negedge clk);
        chk("timeout_one_cycle", tout, 0);
        repeat (6) @(negedge clk);
        pulse_shot(1, 0, 0, 0, 0);
        chk("lastcycle_ack", ack, 1);
        chk("lastcycle_no_timeout", tout, 0);
        chk("lastcycle_turno", turno, 1);
        @(negedge clk);
        chk("lastcycle_turno_after", turno, 0);

        // Randomized play against the game-level model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        m_reload();
        for (int it = 0; it < 300; it++) begin
            if (m_done != 0) begin
                chk("rnd_fin", fin, 1);
                chk("rnd_ganador", ganador, m_winner);
                pulse_start();
                m_reload();
                chk("rnd_restart_mjug", m_jug, 'h1f);
                chk("rnd_restart_mpc", m_pc, 'h1f);
                chk("rnd_restart_turno", turno, 0);
                continue;
            end
            r = $urandom_range(0, 11);
            if (r == 0) begin
                seen = 0;
                repeat (TO - 1) begin
                    @(negedge clk);
                    if (tout) seen = 1;
                end
                @(negedge clk);
                chk("rnd_timeout_early", seen, 0);
                chk("rnd_timeout_pulse", tout, 1);
                m_side = 1 - m_side;
                chk("rnd_timeout_turno", turno, m_side);
            end else begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                side = m_side;
                imp  = ($urandom_range(0, 3) != 0) ? 1 : 0;
                b    = $urandom_range(0, 5);
                both = ($urandom_range(0, 7) == 0) ? 1 : 0;
                st   = ($urandom_range(0, 5) == 0) ? 1 : 0;
                pulse_shot(side, imp, b, both, st);
                m_shot(imp, b);
                chk("rnd_ack", ack, 1);
                chk("rnd_mjug", m_jug, m_mask(0));
                chk("rnd_mpc", m_pc, m_mask(1));
                @(negedge clk);
                chk("rnd_fin_state", fin, m_done);
                if (m_done == 0) chk("rnd_turno", turno, m_side);
            end
        end

        // PC sinks the whole player fleet.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        pulse_shot(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sink_turno_pc", turno, 1);
        for (int s = 0; s < NB; s++) begin
            for (int h = 0; h <= s; h++) begin
                pulse_shot(1, 1, s, 0, 0);
                @(negedge clk);
            end
        end
        chk("sink_mjug", m_jug, 0);
        chk("sink_fin", fin, 1);
        chk("sink_ganador", ganador, 1);
        pulse_shot(1, 1, 0, 1, 0);
        chk("fin_shot_ack", ack, 0);
        chk("fin_mpc_frozen", m_pc, 'h1f);
        chk("fin_mjug_frozen", m_jug, 0);
        chk("fin_held", fin, 1);
        pulse_start();
        chk("restart_mjug", m_jug, 'h1f);
        chk("restart_mpc", m_pc, 'h1f);
        chk("restart_turno", turno, 0);
        chk("restart_fin", fin, 0);

        // Asynchronous reset mid-turn after three hits.
        pulse_shot(0, 1, 0, 0, 0);
        @(negedge clk);
        pulse_shot(0, 1, 4, 0, 0);
        @(negedge clk);
        pulse_shot(0, 0, 1, 0, 0);
        @(negedge clk);
        pulse_shot(1, 1, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_mjug", m_jug, 'h1e);
        chk("pre_rst_turno", turno, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_turno", turno, 0);
        chk("async_rst_mjug", m_jug, 'h1f);
        chk("async_rst_mpc", m_pc, 'h1f);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_shot(0, 1, 0, 0, 0);
        chk("post_rst_needs_start", ack, 0);
        pulse_start();
        pulse_shot(0, 1, 0, 0, 0);
        chk("post_start_ack", ack, 1);
        chk("post_start_mpc", m_pc, 'h1e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_turnos_batalla.md
Name: control_turnos_batalla

Overview:
- Turn scheduler and damage tracker for the two-sided battleship game (player vs. PC).
- Arbitrates which side may fire, accepts one shot per turn, and applies hits to per-ship damage counters.
- Maintains the 5-bit alive masks that drive the seven-segment "ships remaining" displays.
- Detects end of game and enforces a per-turn timeout.

Parameters:
- NUM_BARCOS, 5: ships per side. Ship i (0..4) needs i+1 hits to sink.
- TIMEOUT_CICLOS, 250000000: cycles allowed per turn before the turn is forfeited (5 s at 50 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; starts or restarts a game from IDLE or FIN only.
- jug_disparo  input  1  player shot valid pulse.
- jug_impacto  input  1  player shot hit (1) or miss (0); qualified by jug_disparo.
- jug_barco  input  3  index of the PC ship hit; qualified by jug_impacto.
- pc_disparo  input  1  PC shot valid pulse.
- pc_impacto  input  1  PC shot hit; qualified by pc_disparo.
- pc_barco  input  3  index of the player ship hit.
- turno  output  1  0 = player's turn, 1 = PC's turn.
- barcos_jug  output  5  player ships still afloat, 1 = alive.
- barcos_pc  output  5  PC ships still afloat, 1 = alive.
- disparo_ack  output  1  one-cycle pulse after a shot is accepted.
- timeout  output  1  one-cycle pulse when a turn is forfeited.
- fin_juego  output  1  high while in FIN.
- ganador  output  1  valid when fin_juego = 1; 0 = player won, 1 = PC won.

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE; turno = 0.
  - All damage counters reloaded: ship i = i+1. Both masks = 5'b11111.
  - disparo_ack = timeout = fin_juego = ganador = 0; timeout counter = 0.
  - Reset mid-game aborts the game immediately with no residual state.
- FSM states: IDLE, TURNO_JUG, TURNO_PC, RESOLVER, FIN.
- IDLE: start -> reload counters and masks, turno = 0, go to TURNO_JUG. All shots ignored.
- TURNO_JUG / TURNO_PC:
  - Only the active side's disparo is accepted. The other side's disparo is ignored, including when both arrive in the same cycle.
  - A shot is accepted on edge E:
    - If impacto = 1, barco < 5 and the target counter != 0, that counter decrements at E.
    - The mask bit is the registered (counter != 0), so the display sees the new mask from E.
    - Record hit_valid.
    - Next state = RESOLVER. disparo_ack = 1 for the cycle after E.
  - A hit on an already-sunk ship, or barco >= 5, is treated as a miss.
  - The timeout counter clears on turn entry and increments each cycle in the turn.
    - When it reaches TIMEOUT_CICLOS-1 with no shot: timeout pulses one cycle, turno toggles, and the new turn state is entered.
    - A shot arriving in that same cycle wins; no timeout is raised.
- RESOLVER (exactly one cycle):
  - If the opponent mask == 0: go to FIN; ganador = side that fired.
  - Else if hit_valid: same side keeps the turn.
  - Else: turno toggles.
  - Entering any turn state clears the timeout counter.
- FIN:
  - fin_juego = 1; masks frozen; shots ignored.
  - start -> same reload as from IDLE, go to TURNO_JUG, fin_juego = 0.
- start while in a turn or in RESOLVER is ignored.
- Shot-to-next-turn latency: 2 cycles (accept edge plus RESOLVER).
- Damage counters are 3 bits wide; they never underflow because a decrement is blocked at 0.

Test Plan:
- Reset, then start. Player fires miss (jug_impacto = 0) -> disparo_ack pulses, masks unchanged, turno = 1 two cycles after acceptance.
- Player hits ship 0 -> barcos_pc = 5'b11110 on the accept edge, turno stays 0 after RESOLVER. Then hit ship 4 four times (interleaved misses pass the turn) -> on the 5th hit barcos_pc = 5'b01110.
- TURNO_JUG with pc_disparo and jug_disparo in the same cycle -> only the player's shot is applied; PC shot is ignored, no ack for it.
- TIMEOUT_CICLOS = 8, no shots -> timeout pulses on the 8th turn cycle, turno = 1; a shot on exactly that cycle instead -> normal accept, no timeout.
- PC sinks all player ships (15 hits total) -> barcos_jug = 0, fin_juego = 1, ganador = 1. Further shots are ignored; start -> masks = 5'b11111, turno = 0.
- Assert rst_n low mid-turn after 3 hits -> outputs return to reset values asynchronously; start is then required to resume play.
